// File: rtl/mcoi_reset_sequencer_pkg.sv
// mcoi_reset_sequencer_pkg
// Shared types and helpers for the MCOI reset sequencer.
//   t_rst_seq_state : encoding of the sequencer FSM state (also driven on state_o)
//   clog2_min1      : $clog2 that never returns less than 1, for index widths
package mcoi_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    POR       = 2'd0,
    WAIT_LOCK = 2'd1,
    DELAY     = 2'd2,
    RUN       = 2'd3
  } t_rst_seq_state;

  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mcoi_reset_sequencer_lock_filter.sv
// mcoi_lock_filter
// Brings one asynchronous PLL lock into clk_ik and qualifies it: lock_ok rises
// once the synchronised lock has been high for G_LOCK_FILTER consecutive
// cycles and drops on the first synchronised-low cycle.
// Ports:
//   clk_ik     in  clock
//   rst_ir     in  synchronous active-high reset
//   lock_async in  raw lock input, any timing
//   lock_ok    out qualified lock, registered
module mcoi_lock_filter #(
  parameter int G_LOCK_FILTER = 16
) (
  input  logic clk_ik,
  input  logic rst_ir,
  input  logic lock_async,
  output logic lock_ok
);

  localparam int FW = (G_LOCK_FILTER > 1) ? $clog2(G_LOCK_FILTER) : 1;

  logic [1:0]    sync_q;
  logic [FW-1:0] run_cnt;

  always_ff @(posedge clk_ik) begin
    if (rst_ir) begin
      sync_q  <= '0;
      run_cnt <= '0;
      lock_ok <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], lock_async};
      if (!sync_q[1]) begin
        run_cnt <= '0;
        lock_ok <= 1'b0;
      end else if (!lock_ok) begin
        // run_cnt counts the high cycles already seen; the current one is the last
        if (run_cnt == FW'(G_LOCK_FILTER - 1))
          lock_ok <= 1'b1;
        else
          run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mcoi_reset_sequencer.sv
// mcoi_reset_sequencer
// Power-on and PLL-aware reset sequencer. After a POR hold, channels are
// released one at a time in index order; each waits for its own qualified
// lock and then a fixed inter-stage delay. A lock drop on a released channel
// re-asserts that channel and every later one and resequences from there.
// Ports:
//   clk_ik          in  free-running clock
//   rst_ir          in  synchronous active-high reset
//   locked_i        in  per-channel asynchronous PLL lock
//   soft_reset_i    in  restart the whole sequence from POR
//   lock_lost_clr_i in  clear all lock_lost_o flags
//   reset_o         out per-domain active-high reset requests
//   ready_o         out all channels released
//   state_o         out FSM state
//   stage_o         out channel currently being sequenced
//   lock_lost_o     out sticky per-channel lock-lost flags
//
// state     | meaning
// POR       | counting G_POR_CYCLES after reset / soft reset
// WAIT_LOCK | waiting for lock_ok[stage]
// DELAY     | lock good, counting G_STAGE_DELAY before releasing stage
// RUN       | every channel released
module mcoi_reset_sequencer
  import mcoi_reset_sequencer_pkg::*;
#(
  parameter int G_CHANNELS    = 4,
  parameter int G_CNT_WIDTH   = 21,
  parameter int G_POR_CYCLES  = 2097151,
  parameter int G_STAGE_DELAY = 1000,
  parameter int G_LOCK_FILTER = 16
) (
  input  logic                                clk_ik,
  input  logic                                rst_ir,
  input  logic [G_CHANNELS-1:0]               locked_i,
  input  logic                                soft_reset_i,
  input  logic                                lock_lost_clr_i,
  output logic [G_CHANNELS-1:0]               reset_o,
  output logic                                ready_o,
  output logic [1:0]                          state_o,
  output logic [clog2_min1(G_CHANNELS)-1:0]   stage_o,
  output logic [G_CHANNELS-1:0]               lock_lost_o
);

  localparam int SW = clog2_min1(G_CHANNELS);

  localparam logic [1:0] ST_POR       = 2'(POR);
  localparam logic [1:0] ST_WAIT_LOCK = 2'(WAIT_LOCK);
  localparam logic [1:0] ST_DELAY     = 2'(DELAY);
  localparam logic [1:0] ST_RUN       = 2'(RUN);

  logic [G_CHANNELS-1:0]  lock_ok;
  logic [1:0]             state;
  logic [SW-1:0]          stage;
  logic [G_CNT_WIDTH-1:0] cnt;
  logic [G_CNT_WIDTH-1:0] cnt_inc;

  logic [G_CHANNELS-1:0]  lost_vec;
  logic [G_CHANNELS-1:0]  lost_onehot;
  logic [G_CHANNELS-1:0]  lost_mask;
  logic [SW-1:0]          lost_idx;
  logic                   lost_any;
  logic                   lock_cur;
  logic                   last_stage;

  for (genvar k = 0; k < G_CHANNELS; k++) begin : g_lock
    mcoi_lock_filter #(
      .G_LOCK_FILTER(G_LOCK_FILTER)
    ) u_lock_filter (
      .clk_ik    (clk_ik),
      .rst_ir    (rst_ir),
      .lock_async(locked_i[k]),
      .lock_ok   (lock_ok[k])
    );
  end

  // A released channel whose lock is no longer good; the lowest one wins and
  // everything from it upwards goes back into reset.
  always_comb begin
    lost_vec    = ~reset_o & ~lock_ok;
    lost_any    = |lost_vec;
    lost_idx    = '0;
    lost_onehot = '0;
    for (int k = G_CHANNELS - 1; k >= 0; k--) begin
      if (lost_vec[k]) begin
        lost_idx    = SW'(k);
        lost_onehot = G_CHANNELS'(1) << k;
      end
    end
    lost_mask = lost_any ? ~(lost_onehot - G_CHANNELS'(1)) : '0;
  end

  assign cnt_inc    = (cnt == '1) ? cnt : cnt + 1'b1;
  assign lock_cur   = lock_ok[stage];
  assign last_stage = (stage == SW'(G_CHANNELS - 1));

  always_ff @(posedge clk_ik) begin
    if (rst_ir) begin
      state       <= ST_POR;
      stage       <= '0;
      cnt         <= '0;
      reset_o     <= '1;
      ready_o     <= 1'b0;
      lock_lost_o <= '0;
    end else begin
      // a new loss outranks a clear in the same cycle, and is recorded even
      // when a soft reset takes the FSM elsewhere
      lock_lost_o <= (lock_lost_o & ~{G_CHANNELS{lock_lost_clr_i}}) | lost_onehot;

      if (soft_reset_i) begin
        state   <= ST_POR;
        stage   <= '0;
        cnt     <= '0;
        reset_o <= '1;
        ready_o <= 1'b0;
      end else if (lost_any) begin
        state   <= ST_WAIT_LOCK;
        stage   <= lost_idx;
        cnt     <= '0;
        reset_o <= reset_o | lost_mask;
        ready_o <= 1'b0;
      end else begin
        case (state)
          ST_POR: begin
            if (cnt == G_CNT_WIDTH'(G_POR_CYCLES - 1)) begin
              state <= ST_WAIT_LOCK;
              stage <= '0;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          ST_WAIT_LOCK: begin
            if (lock_cur) begin
              state <= ST_DELAY;
              cnt   <= '0;
            end
          end
          ST_DELAY: begin
            if (!lock_cur) begin
              state <= ST_WAIT_LOCK;
              cnt   <= '0;
            end else if (cnt == G_CNT_WIDTH'(G_STAGE_DELAY - 1)) begin
              reset_o[stage] <= 1'b0;
              cnt            <= '0;
              if (last_stage) begin
                state   <= ST_RUN;
                ready_o <= 1'b1;
              end else begin
                state <= ST_WAIT_LOCK;
                stage <= stage + 1'b1;
              end
            end else begin
              cnt <= cnt_inc;
            end
          end
          ST_RUN: begin
          end
          default: state <= ST_POR;
        endcase
      end
    end
  end

  assign state_o = state;
  assign stage_o = stage;

endmodule

// File: tb/tb_mcoi_reset_sequencer.sv
// tb_mcoi_reset_sequencer
// Edge numbering: edge 0 is the last edge that samples rst_ir high; inputs are
// changed 1 time unit after an edge, so a value driven after edge e is first
// sampled at edge e+1. Every reset_o change is matched against a queue of
// expected (edge, value, ready) entries pushed when the stimulus is applied.
module tb_mcoi_reset_sequencer;

  localparam int N    = 4;
  localparam int POR  = 16;
  localparam int DLY  = 4;
  localparam int FLT  = 3;
  localparam int CW   = 5;
  // first release after reset / soft reset, and spacing between stages
  localparam int REL0 = POR + 1 + DLY;
  localparam int STEP = 1 + DLY;
  // edges from "input changed after edge e" to the resulting release:
  // 2 synchroniser edges, FLT filter edges, 1 WAIT->DELAY, DLY delay edges
  localparam int LOCK_REL = 2 + FLT + 1 + DLY;

  logic         clk_ik = 1'b0;
  logic         rst_ir;
  logic [N-1:0] locked_i;
  logic         soft_reset_i;
  logic         lock_lost_clr_i;
  logic [N-1:0] reset_o;
  logic         ready_o;
  logic [1:0]   state_o;
  logic [1:0]   stage_o;
  logic [N-1:0] lock_lost_o;

  typedef struct {
    int         ev_edge;
    logic [3:0] rst;
    logic       rdy;
  } t_exp;

  t_exp       sb[$];
  int         edge_n = 0;
  int         base   = 0;
  int         n_chk  = 0;
  int         n_fail = 0;
  logic       mon_en = 1'b0;
  logic [3:0] prev_rst;

  always #5 clk_ik = ~clk_ik;
  always @(posedge clk_ik) edge_n <= edge_n + 1;

  mcoi_reset_sequencer #(
    .G_CHANNELS   (N),
    .G_CNT_WIDTH  (CW),
    .G_POR_CYCLES (POR),
    .G_STAGE_DELAY(DLY),
    .G_LOCK_FILTER(FLT)
  ) dut (
    .clk_ik         (clk_ik),
    .rst_ir         (rst_ir),
    .locked_i       (locked_i),
    .soft_reset_i   (soft_reset_i),
    .lock_lost_clr_i(lock_lost_clr_i),
    .reset_o        (reset_o),
    .ready_o        (ready_o),
    .state_o        (state_o),
    .stage_o        (stage_o),
    .lock_lost_o    (lock_lost_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n - base);
    end
  endtask

  task automatic push(input int e, input logic [3:0] r, input logic rdy);
    t_exp x;
    x.ev_edge = e;
    x.rst     = r;
    x.rdy     = rdy;
    sb.push_back(x);
  endtask

  task automatic push_seq(input int first, input logic [3:0] start);
    logic [3:0] r;
    r = start;
    for (int k = 0; k < N; k++) begin
      if (r[k]) begin
        r[k] = 1'b0;
        push(first, r, (r == 4'b0000));
        first += STEP;
      end
    end
  endtask

  task automatic wait_rel(input int r);
    while (edge_n < base + r) begin
      @(posedge clk_ik);
      #1;
    end
  endtask

  task automatic do_reset(input logic [3:0] locks);
    mon_en   = 1'b0;
    rst_ir   = 1'b1;
    locked_i = locks;
    repeat (3) begin
      @(posedge clk_ik);
      #1;
    end
    base     = edge_n;
    rst_ir   = 1'b0;
    prev_rst = reset_o;
    mon_en   = 1'b1;
  endtask

  always @(negedge clk_ik) begin
    t_exp e;
    if (mon_en && (reset_o !== prev_rst)) begin
      if (sb.size() == 0) begin
        chk("rst_unexpected", 32'(reset_o), 32'(prev_rst));
      end else begin
        e = sb.pop_front();
        chk("rst_edge", edge_n - base, e.ev_edge);
        chk("rst_val", 32'(reset_o), 32'(e.rst));
        chk("rst_ready", 32'(ready_o), 32'(e.rdy));
      end
      prev_rst = reset_o;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_ir          = 1'b1;
    locked_i        = '1;
    soft_reset_i    = 1'b0;
    lock_lost_clr_i = 1'b0;

    // 1. nominal release with all locks good
    do_reset(4'b1111);
    chk("rst_reset_o", 32'(reset_o), 32'hf);
    chk("rst_ready", 32'(ready_o), 32'h0);
    chk("rst_state", 32'(state_o), 32'h0);
    chk("rst_stage", 32'(stage_o), 32'h0);
    chk("rst_lost", 32'(lock_lost_o), 32'h0);
    push_seq(REL0, 4'b1111);
    wait_rel(REL0 + 3 * STEP + 1);
    chk("nom_state", 32'(state_o), 32'h3);
    chk("nom_ready", 32'(ready_o), 32'h1);
    chk("nom_stage", 32'(stage_o), 32'h3);
    chk("nom_sb_empty", sb.size(), 0);

    // 2. late lock on channel 2, with a short glitch while waiting
    do_reset(4'b1011);
    push(REL0, 4'b1110, 1'b0);
    push(REL0 + STEP, 4'b1100, 1'b0);
    wait_rel(35); locked_i[2] = 1'b1;
    wait_rel(37); locked_i[2] = 1'b0;
    wait_rel(45);
    chk("late_state", 32'(state_o), 32'h1);
    chk("late_stage", 32'(stage_o), 32'h2);
    chk("glitch_reset", 32'(reset_o), 32'hc);
    wait_rel(50); locked_i[2] = 1'b1;
    push_seq(50 + LOCK_REL, 4'b1100);
    wait_rel(70);
    chk("late_ready", 32'(ready_o), 32'h1);

    // 3. one-cycle lock loss on channel 1 while running
    wait_rel(99);  locked_i[1] = 1'b0;
    wait_rel(100); locked_i[1] = 1'b1;
    push(103, 4'b1110, 1'b0);
    push(100 + LOCK_REL, 4'b1100, 1'b0);
    wait_rel(104);
    chk("loss_lost", 32'(lock_lost_o), 32'h2);
    chk("loss_state", 32'(state_o), 32'h1);
    chk("loss_stage", 32'(stage_o), 32'h1);
    chk("loss_ready", 32'(ready_o), 32'h0);

    // 4. soft reset during DELAY of stage 2
    wait_rel(112);
    chk("soft_pre_state", 32'(state_o), 32'h2);
    chk("soft_pre_stage", 32'(stage_o), 32'h2);
    soft_reset_i = 1'b1;
    push(113, 4'b1111, 1'b0);
    push_seq(113 + REL0, 4'b1111);
    wait_rel(113); soft_reset_i = 1'b0;
    chk("soft_state", 32'(state_o), 32'h0);
    chk("soft_stage", 32'(stage_o), 32'h0);
    chk("soft_lost", 32'(lock_lost_o), 32'h2);
    wait_rel(113 + POR - 1);
    chk("soft_por_hold", 32'(state_o), 32'h0);
    wait_rel(113 + POR);
    chk("soft_por_end", 32'(state_o), 32'h1);

    // 5a. soft reset in the same cycle as a channel 0 lock loss
    wait_rel(159); locked_i[0] = 1'b0;
    wait_rel(160); locked_i[0] = 1'b1;
    wait_rel(162); soft_reset_i = 1'b1;
    push(163, 4'b1111, 1'b0);
    push_seq(163 + REL0, 4'b1111);
    wait_rel(163); soft_reset_i = 1'b0;
    chk("sim_state", 32'(state_o), 32'h0);
    chk("sim_lost", 32'(lock_lost_o), 32'h3);

    // 5b. clear in the same cycle as a new loss on channel 1
    wait_rel(209); locked_i[1] = 1'b0;
    wait_rel(210); locked_i[1] = 1'b1;
    wait_rel(212); lock_lost_clr_i = 1'b1;
    push(213, 4'b1110, 1'b0);
    push_seq(210 + LOCK_REL, 4'b1110);
    wait_rel(213); lock_lost_clr_i = 1'b0;
    wait_rel(214);
    chk("clr_set_lost", 32'(lock_lost_o), 32'h2);
    wait_rel(234); lock_lost_clr_i = 1'b1;
    wait_rel(235); lock_lost_clr_i = 1'b0;
    wait_rel(236);
    chk("clr_lost", 32'(lock_lost_o), 32'h0);

    // 6. rst_ir while channel 2 is in DELAY after a loss
    wait_rel(239); locked_i[2] = 1'b0;
    wait_rel(240); locked_i[2] = 1'b1;
    push(243, 4'b1100, 1'b0);
    wait_rel(244);
    chk("loss2_lost", 32'(lock_lost_o), 32'h4);
    chk("loss2_stage", 32'(stage_o), 32'h2);
    wait_rel(247);
    chk("mid_delay_state", 32'(state_o), 32'h2);
    rst_ir = 1'b1;
    push(248, 4'b1111, 1'b0);
    push_seq(248 + REL0, 4'b1111);
    wait_rel(248); rst_ir = 1'b0;
    chk("rstmid_reset_o", 32'(reset_o), 32'hf);
    chk("rstmid_state", 32'(state_o), 32'h0);
    chk("rstmid_stage", 32'(stage_o), 32'h0);
    chk("rstmid_ready", 32'(ready_o), 32'h0);
    chk("rstmid_lost", 32'(lock_lost_o), 32'h0);
    wait_rel(248 + REL0 + 3 * STEP + 6);
    chk("final_state", 32'(state_o), 32'h3);
    chk("final_ready", 32'(ready_o), 32'h1);
    chk("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
